fault_recovery_ctrl: RTL and testbench

//  Sequences the CPU's response to the 2-bit fault code from the fault classifier (00 none, 01 minor, 10 critical).

---
 rtl/fault_pkg.sv | 21 ++
 rtl/fault_recovery_ctrl_sat_counter.sv | 23 ++
 rtl/fault_recovery_ctrl.sv | 128 ++++++++++++
 tb/tb_fault_recovery_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared fault-classifier codes and recovery FSM state encodings.
// Used by the fault classifier and by fault_recovery_ctrl.
package fault_pkg;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MINOR    = 2'b01;
  localparam logic [1:0] FAULT_CRITICAL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_RECOVER = 2'b10,
    ST_HALT    = 2'b11
  } state_e;

  // Code 2'b11 is unassigned by the classifier and is handled as critical.
  function automatic logic is_critical(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/fault_recovery_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/fault_recovery_ctrl.sv
// CPU fault recovery sequencer: flush/redirect/retry on minor faults,
// sticky halt on critical faults or exhausted retries, plus fault statistics.
module fault_recovery_ctrl
  import fault_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 3,
  parameter int RETRY_W      = 2,
  parameter int MAX_RETRY    = 2,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         fault_type,
  input  logic [PC_W-1:0]    fault_pc,
  input  logic               instr_retired,
  input  logic               clear_halt,
  output logic               stall,
  output logic               flush,
  output logic               pc_redirect,
  output logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [CNT_W-1:0]   minor_count,
  output logic [CNT_W-1:0]   critical_count
);

  localparam int                   FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]      FC_LOAD   = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_e               state_q;
  logic [FC_W-1:0]      flush_cnt_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [PC_W-1:0]      pc_q;
  logic                 redirect_q;

  logic crit;
  logic minor;
  logic minor_inc;
  logic crit_inc;

  assign crit  = is_critical(fault_type);
  assign minor = (fault_type == FAULT_MINOR);

  // Statistics: faults are only counted where the FSM acts on them.
  assign crit_inc  = crit && (state_q != ST_HALT);
  assign minor_inc = minor && ((state_q == ST_IDLE) || (state_q == ST_RECOVER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      retry_q     <= '0;
      pc_q        <= '0;
      redirect_q  <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (crit) begin
            state_q <= ST_HALT;
          end else if (minor) begin
            pc_q        <= fault_pc;
            retry_q     <= RETRY_W'(1);
            flush_cnt_q <= FC_LOAD;
            state_q     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (crit) begin
            state_q <= ST_HALT;
          end else if (flush_cnt_q == '0) begin
            state_q    <= ST_RECOVER;
            redirect_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q - FC_W'(1);
          end
        end
        ST_RECOVER: begin
          if (crit) begin
            state_q <= ST_HALT;
          end else if (minor && (retry_q == RETRY_MAX)) begin
            state_q <= ST_HALT;
          end else if (minor) begin
            pc_q        <= fault_pc;
            retry_q     <= retry_q + RETRY_W'(1);
            flush_cnt_q <= FC_LOAD;
            state_q     <= ST_FLUSH;
          end else if (instr_retired) begin
            retry_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_HALT: begin
          // A critical fault arriving with the release keeps the core halted.
          if (clear_halt && !crit) begin
            retry_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall       = (state_q == ST_FLUSH) || (state_q == ST_HALT);
  assign flush       = (state_q == ST_FLUSH);
  assign halted      = (state_q == ST_HALT);
  assign pc_redirect = redirect_q;
  assign redirect_pc = pc_q;
  assign retry_cnt   = retry_q;

  sat_counter #(.W(CNT_W)) u_minor_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (minor_inc),
    .count (minor_count)
  );

  sat_counter #(.W(CNT_W)) u_crit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (crit_inc),
    .count (critical_count)
  );

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Directed bench for fault_recovery_ctrl: a reference model pushes expected
// outputs to a scoreboard queue each cycle, popped and compared after the edge.
module tb_fault_recovery_ctrl;

  localparam int PC_W = 32;
  localparam int FC   = 3;
  localparam int RW   = 2;
  localparam int MR   = 2;
  localparam int CW   = 2;
  localparam int VW   = 4 + RW + 2 * CW + PC_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      fault_type = 2'b00;
  logic [PC_W-1:0] fault_pc = '0;
  logic            instr_retired = 1'b0;
  logic            clear_halt = 1'b0;
  logic            stall, flush, pc_redirect, halted;
  logic [PC_W-1:0] redirect_pc;
  logic [RW-1:0]   retry_cnt;
  logic [CW-1:0]   minor_count, critical_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string         tag;
    logic [VW-1:0] val;
  } exp_t;
  exp_t sb[$];

  // Reference model state (0 IDLE, 1 FLUSH, 2 RECOVER, 3 HALT)
  int            m_state;
  int            m_fcnt;
  int            m_retry;
  logic [PC_W-1:0] m_pc;
  logic          m_redir;
  int            m_minor;
  int            m_crit;

  fault_recovery_ctrl #(
    .PC_W(PC_W), .FLUSH_CYCLES(FC), .RETRY_W(RW), .MAX_RETRY(MR), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .fault_type(fault_type), .fault_pc(fault_pc),
    .instr_retired(instr_retired), .clear_halt(clear_halt),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .halted(halted), .retry_cnt(retry_cnt),
    .minor_count(minor_count), .critical_count(critical_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic st, fl, hl;
    st = (m_state == 1) || (m_state == 3);
    fl = (m_state == 1);
    hl = (m_state == 3);
    return {st, fl, m_redir, hl, RW'(m_retry), CW'(m_minor), CW'(m_crit), m_pc};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {stall, flush, pc_redirect, halted, retry_cnt, minor_count, critical_count, redirect_pc};
  endfunction

  task automatic model_reset();
    m_state = 0; m_fcnt = 0; m_retry = 0; m_pc = '0; m_redir = 1'b0;
    m_minor = 0; m_crit = 0;
  endtask

  task automatic model_tick(input logic [1:0] ft, input logic [PC_W-1:0] pc,
                            input logic ret, input logic clr);
    logic is_crit, is_minor;
    is_crit  = (ft == 2'b10) || (ft == 2'b11);
    is_minor = (ft == 2'b01);
    m_redir  = 1'b0;
    case (m_state)
      0: if (is_crit) begin
           m_state = 3; m_crit = sat(m_crit);
         end else if (is_minor) begin
           m_pc = pc; m_retry = 1; m_minor = sat(m_minor); m_fcnt = FC - 1; m_state = 1;
         end
      1: if (is_crit) begin
           m_state = 3; m_crit = sat(m_crit);
         end else if (m_fcnt == 0) begin
           m_state = 2; m_redir = 1'b1;
         end else begin
           m_fcnt--;
         end
      2: if (is_crit) begin
           m_state = 3; m_crit = sat(m_crit);
         end else if (is_minor && m_retry == MR) begin
           m_state = 3; m_minor = sat(m_minor);
         end else if (is_minor) begin
           m_pc = pc; m_retry++; m_minor = sat(m_minor); m_fcnt = FC - 1; m_state = 1;
         end else if (ret) begin
           m_state = 0; m_retry = 0;
         end
      default: if (clr && !is_crit) begin
           m_state = 0; m_retry = 0;
         end
    endcase
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, dut_vec(), e.val);
  endtask

  // Drive one cycle of inputs, advance the model, and score the DUT.
  task automatic step(input logic [1:0] ft, input logic [PC_W-1:0] pc,
                      input logic ret, input logic clr, input string tag);
    fault_type = ft; fault_pc = pc; instr_retired = ret; clear_halt = clr;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_tick(ft, pc, ret, clr);
    sb.push_back('{tag, model_vec()});
    pop_check();
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(2'b00, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    step(2'b00, '0, 1'b0, 1'b0, "reset_pulse");
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // 1: reset held with random inputs
    for (int i = 0; i < 4; i++)
      step(2'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom), "rst_random");
    chk("rst_all_zero", dut_vec(), '0);
    rst = 1'b0;
    idle(1, "post_release_idle");

    // 2: single minor fault
    step(2'b01, 32'h100, 1'b0, 1'b0, "minor_accept");
    chk("flush_hi_1", {31'd0, flush, stall}, 33'b11);
    idle(2, "flush_hold");
    idle(1, "enter_recover");
    chk("redirect_pulse", {31'd0, pc_redirect}, 32'd1);
    chk("redirect_pc_100", redirect_pc, 32'h100);
    idle(1, "recover_wait");
    step(2'b00, '0, 1'b1, 1'b0, "retire_to_idle");
    chk("minor_count_1", minor_count, 2'd1);

    // 3: retries exhausted
    sync_reset();
    step(2'b01, 32'h200, 1'b0, 1'b0, "r1_minor");
    idle(3, "r1_flush");
    step(2'b01, 32'h204, 1'b0, 1'b0, "r2_minor");
    chk("retry_2", retry_cnt, 2'd2);
    idle(3, "r2_flush");
    step(2'b01, 32'h208, 1'b0, 1'b0, "r3_minor_halt");
    chk("halt_exhausted", {halted, minor_count, critical_count}, {1'b1, 2'd3, 2'd0});
    step(2'b00, '0, 1'b0, 1'b1, "clear_after_exhaust");

    // 4: critical during flush
    sync_reset();
    step(2'b01, 32'h300, 1'b0, 1'b0, "c_minor");
    idle(1, "c_flush");
    step(2'b10, 32'h304, 1'b0, 1'b0, "crit_in_flush");
    chk("crit_halt", {halted, flush, critical_count}, {1'b1, 1'b0, 2'd1});
    idle(2, "halt_sticky");
    step(2'b00, '0, 1'b0, 1'b1, "clear_halt");
    chk("retry_cleared", {halted, retry_cnt}, 3'b000);

    // 5: priority cases
    step(2'b01, 32'h400, 1'b0, 1'b0, "p_minor");
    idle(3, "p_flush");
    step(2'b01, 32'h404, 1'b1, 1'b0, "minor_beats_retire");
    chk("fault_wins", {flush, redirect_pc}, {1'b1, 32'h404});
    step(2'b10, '0, 1'b0, 1'b0, "p_crit");
    step(2'b10, '0, 1'b0, 1'b1, "clear_vs_crit");
    chk("stay_halt", {halted, critical_count}, {1'b1, 2'd2});
    step(2'b00, '0, 1'b0, 1'b1, "p_clear");

    // 6: saturation, code 11, async reset mid-flush
    sync_reset();
    for (int k = 0; k < 5; k++) begin
      step(2'b01, 32'h500 + 32'(k), 1'b0, 1'b0, "sat_minor");
      idle(4, "sat_flush_recover");
      step(2'b00, '0, 1'b1, 1'b0, "sat_retire");
    end
    chk("minor_saturated", minor_count, 2'd3);
    step(2'b11, '0, 1'b0, 1'b0, "code11_crit");
    chk("code11_halt", {halted, critical_count}, {1'b1, 2'd1});
    step(2'b00, '0, 1'b0, 1'b1, "code11_clear");
    step(2'b01, 32'h600, 1'b0, 1'b0, "ar_minor");
    idle(1, "ar_flush");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_zero", dut_vec(), '0);
    model_reset();
    step(2'b00, '0, 1'b0, 1'b0, "ar_held");
    rst = 1'b0;
    idle(4, "ar_no_redirect");

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
